// File: rtl/pipeline_pkg.sv
// Shared pipeline types: the decode control bundle, its zero (bubble) value and ALU op encodings.
package pipeline_pkg;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_dst;
        logic [2:0] alu_op;
    } id_ctrl_t;

    localparam id_ctrl_t CTRL_NOP = 9'b0_0000_0000;

    localparam logic [2:0] ALU_OP_ADD   = 3'b000;
    localparam logic [2:0] ALU_OP_SUB   = 3'b001;
    localparam logic [2:0] ALU_OP_RTYPE = 3'b010;
    localparam logic [2:0] ALU_OP_AND   = 3'b011;
    localparam logic [2:0] ALU_OP_OR    = 3'b100;
    localparam logic [2:0] ALU_OP_SLT   = 3'b101;
    localparam logic [2:0] ALU_OP_LUI   = 3'b110;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard check of the decode instruction against the load held in EX.
module load_use_detector (
    input  logic       ex_mem_read,
    input  logic       ex_valid,
    input  logic [4:0] ex_rt,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       hazard
);

    logic rt_nonzero_s;
    logic rs_match_s;
    logic rt_match_s;

    // $0 is hardwired, so a load targeting it can never feed a consumer
    assign rt_nonzero_s = (ex_rt != 5'd0);
    assign rs_match_s   = (ex_rt == id_rs);
    assign rt_match_s   = id_uses_rt & (ex_rt == id_rt);
    assign hazard       = ex_valid & ex_mem_read & id_valid & rt_nonzero_s
                          & (rs_match_s | rt_match_s);

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use bubble insertion, flush/hold handling and a stall counter.
module id_ex_register
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_data1,
    input  logic [31:0] id_data2,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        id_uses_rt,
    input  id_ctrl_t    id_ctrl,
    input  logic        flush,
    input  logic        ex_hold,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_data1,
    output logic [31:0] ex_data2,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output id_ctrl_t    ex_ctrl,
    output logic        hold_out,
    output logic [15:0] stall_count
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] data1_q, data1_d;
    logic [31:0] data2_q, data2_d;
    logic [31:0] imm_q, imm_d;
    logic [4:0]  rs_q, rs_d;
    logic [4:0]  rt_q, rt_d;
    logic [4:0]  rd_q, rd_d;
    id_ctrl_t    ctrl_q, ctrl_d;
    logic [15:0] stall_q, stall_d;
    logic        hazard_s;

    load_use_detector u_load_use_detector (
        .ex_mem_read (ctrl_q.mem_read),
        .ex_valid    (valid_q),
        .ex_rt       (rt_q),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .hazard      (hazard_s)
    );

    // A flush squashes the decode slot, so it also cancels any freeze request
    assign hold_out = ~rst & ~flush & (hazard_s | ex_hold);

    // Next-state selection: flush > hold > hazard bubble > normal capture
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        pc_d    = pc_q;
        data1_d = data1_q;
        data2_d = data2_q;
        imm_d   = imm_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_NOP;
        end else if (ex_hold) begin
            valid_d = valid_q;
        end else if (hazard_s) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_NOP;
        end else begin
            valid_d = id_valid;
            ctrl_d  = id_ctrl;
            pc_d    = id_pc;
            data1_d = id_data1;
            data2_d = id_data2;
            imm_d   = id_imm;
            rs_d    = id_rs;
            rt_d    = id_rt;
            rd_d    = id_rd;
        end
    end

    // Stall counter advances on every frozen cycle and wraps naturally
    always_comb begin
        if (hold_out) begin
            stall_d = stall_q + 16'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Pipeline and counter state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_NOP;
            pc_q    <= 32'd0;
            data1_q <= 32'd0;
            data2_q <= 32'd0;
            imm_q   <= 32'd0;
            rs_q    <= 5'd0;
            rt_q    <= 5'd0;
            rd_q    <= 5'd0;
            stall_q <= 16'd0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            pc_q    <= pc_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            stall_q <= stall_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_ctrl     = ctrl_q;
    assign ex_pc       = pc_q;
    assign ex_data1    = data1_q;
    assign ex_data2    = data2_q;
    assign ex_imm      = imm_q;
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_rd       = rd_q;
    assign stall_count = stall_q;

endmodule
